// File: rtl/cpu15_pkg.sv
// Shared cpu15 register-file constants and types, common to the write-back and
// operand-read stages.
package cpu15_pkg;
  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 3;
  localparam int NREG       = 8;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] n;
    logic                  en;
  } wr_req_t;
endpackage

// File: rtl/reg_rd_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on
// write-back. A set and a clear of the same bit in one cycle leave the bit set.
module reg_scoreboard
  import cpu15_pkg::*;
(
  input  logic                  CLK_WB,
  input  logic                  RESET_N,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_idx,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_idx,
  output logic [NREG-1:0]       busy
);
  logic [NREG-1:0] busy_nxt;

  always_comb begin
    busy_nxt = busy;
    if (clr_en) busy_nxt[clr_idx] = 1'b0;
    if (set_en) busy_nxt[set_idx] = 1'b1;
  end

  always_ff @(posedge CLK_WB) begin
    if (!RESET_N) busy <= '0;
    else          busy <= busy_nxt;
  end
endmodule

// File: rtl/reg_rd.sv
// cpu15 operand-read stage: picks two sources from the register file, forwards
// a same-cycle write-back, interlocks on pending writes, and holds one slot for execute.
module reg_rd
  import cpu15_pkg::*;
#(
  parameter int DATA_W    = cpu15_pkg::DATA_W,
  parameter bit BYPASS_EN = 1'b1
)(
  input  logic              CLK_WB,
  input  logic              RESET_N,
  input  logic [DATA_W-1:0] REG_0,
  input  logic [DATA_W-1:0] REG_1,
  input  logic [DATA_W-1:0] REG_2,
  input  logic [DATA_W-1:0] REG_3,
  input  logic [DATA_W-1:0] REG_4,
  input  logic [DATA_W-1:0] REG_5,
  input  logic [DATA_W-1:0] REG_6,
  input  logic [DATA_W-1:0] REG_7,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [2:0]        N_REG_A,
  input  logic [2:0]        N_REG_B,
  input  logic [2:0]        N_REG_D,
  input  logic              D_WEN,
  input  logic [2:0]        WB_N_REG,
  input  logic [DATA_W-1:0] WB_REG_IN,
  input  logic              WB_REG_WEN,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OP_A,
  output logic [DATA_W-1:0] OP_B,
  output logic [2:0]        OUT_N_REG_D,
  output logic              OUT_D_WEN,
  output logic [7:0]        BUSY
);
  logic [NREG-1:0][DATA_W-1:0] rf;
  logic [NREG-1:0]             busy;
  logic                        hit_a, hit_b, hit_d;
  logic                        haz_a, haz_b, haz_d;
  logic                        accept;
  logic [DATA_W-1:0]           op_a_nxt, op_b_nxt;
  wr_req_t                     dst;

  assign rf = {REG_7, REG_6, REG_5, REG_4, REG_3, REG_2, REG_1, REG_0};

  assign hit_a = WB_REG_WEN && (WB_N_REG == N_REG_A);
  assign hit_b = WB_REG_WEN && (WB_N_REG == N_REG_B);
  assign hit_d = WB_REG_WEN && (WB_N_REG == N_REG_D);

  // Without forwarding, a source written this cycle is only readable from the
  // register file after the edge, so it stalls one cycle.
  assign haz_a = BYPASS_EN ? (busy[N_REG_A] && !hit_a) : (busy[N_REG_A] || hit_a);
  assign haz_b = BYPASS_EN ? (busy[N_REG_B] && !hit_b) : (busy[N_REG_B] || hit_b);
  assign haz_d = D_WEN && busy[N_REG_D] && !hit_d;

  assign IN_READY = RESET_N && !haz_a && !haz_b && !haz_d && (!OUT_VALID || OUT_READY);
  assign accept   = IN_VALID && IN_READY;

  assign op_a_nxt = (BYPASS_EN && hit_a) ? WB_REG_IN : rf[N_REG_A];
  assign op_b_nxt = (BYPASS_EN && hit_b) ? WB_REG_IN : rf[N_REG_B];

  assign dst.n  = N_REG_D;
  assign dst.en = D_WEN;

  always_ff @(posedge CLK_WB) begin
    if (!RESET_N) begin
      OUT_VALID   <= 1'b0;
      OP_A        <= '0;
      OP_B        <= '0;
      OUT_N_REG_D <= '0;
      OUT_D_WEN   <= 1'b0;
    end else if (accept) begin
      OUT_VALID   <= 1'b1;
      OP_A        <= op_a_nxt;
      OP_B        <= op_b_nxt;
      OUT_N_REG_D <= dst.n;
      OUT_D_WEN   <= dst.en;
    end else if (OUT_READY) begin
      OUT_VALID   <= 1'b0;
    end
  end

  reg_scoreboard u_sb (
    .CLK_WB  (CLK_WB),
    .RESET_N (RESET_N),
    .set_en  (accept && D_WEN),
    .set_idx (N_REG_D),
    .clr_en  (WB_REG_WEN),
    .clr_idx (WB_N_REG),
    .busy    (busy)
  );

  assign BUSY = busy;
endmodule

// File: tb/tb_reg_rd.sv
// Directed bench for reg_rd: a per-cycle vector table on the forwarding
// variant, then hand sequences for back-pressure, reset-in-stall and no-forwarding.
module tb_reg_rd;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] rf [8];
  logic        iv, ordy, dwen, wen;
  logic [2:0]  a, b, d, wn;
  logic [15:0] wd;

  logic        rdy1, ov1, odw1, rdy0, ov0, odw0;
  logic [15:0] opa1, opb1, opa0, opb0;
  logic [2:0]  od1, od0;
  logic [7:0]  busy1, busy0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_rd #(.BYPASS_EN(1'b1)) dut1 (
    .CLK_WB(clk), .RESET_N(rst_n),
    .REG_0(rf[0]), .REG_1(rf[1]), .REG_2(rf[2]), .REG_3(rf[3]),
    .REG_4(rf[4]), .REG_5(rf[5]), .REG_6(rf[6]), .REG_7(rf[7]),
    .IN_VALID(iv), .IN_READY(rdy1), .N_REG_A(a), .N_REG_B(b), .N_REG_D(d),
    .D_WEN(dwen), .WB_N_REG(wn), .WB_REG_IN(wd), .WB_REG_WEN(wen),
    .OUT_VALID(ov1), .OUT_READY(ordy), .OP_A(opa1), .OP_B(opb1),
    .OUT_N_REG_D(od1), .OUT_D_WEN(odw1), .BUSY(busy1)
  );

  reg_rd #(.BYPASS_EN(1'b0)) dut0 (
    .CLK_WB(clk), .RESET_N(rst_n),
    .REG_0(rf[0]), .REG_1(rf[1]), .REG_2(rf[2]), .REG_3(rf[3]),
    .REG_4(rf[4]), .REG_5(rf[5]), .REG_6(rf[6]), .REG_7(rf[7]),
    .IN_VALID(iv), .IN_READY(rdy0), .N_REG_A(a), .N_REG_B(b), .N_REG_D(d),
    .D_WEN(dwen), .WB_N_REG(wn), .WB_REG_IN(wd), .WB_REG_WEN(wen),
    .OUT_VALID(ov0), .OUT_READY(ordy), .OP_A(opa0), .OP_B(opb0),
    .OUT_N_REG_D(od0), .OUT_D_WEN(odw0), .BUSY(busy0)
  );

  typedef struct {
    logic        iv;
    logic [2:0]  a, b, d;
    logic        dwen, wen;
    logic [2:0]  wn;
    logic [15:0] wd;
    logic        rdy, ov;
    logic [15:0] opa, opb;
    logic [2:0]  od;
    logic        odw;
    logic [7:0]  busy;
  } vec_t;

  vec_t vt [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Models the write-back block: register file updates on the same edge as the write.
  task automatic tick();
    logic       w;
    logic [2:0] n;
    logic [15:0] v;
    w = wen; n = wn; v = wd;
    @(posedge clk);
    #1;
    if (w && rst_n) rf[n] = v;
  endtask

  task automatic drive(input logic i_v, input logic [2:0] i_a, input logic [2:0] i_b,
                       input logic [2:0] i_d, input logic i_dw, input logic i_w,
                       input logic [2:0] i_n, input logic [15:0] i_wd);
    iv = i_v; a = i_a; b = i_b; d = i_d; dwen = i_dw; wen = i_w; wn = i_n; wd = i_wd;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 16'h0);
    ordy = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = 16'h1000 + 16'(i);
    rf[2] = 16'h1234;
    rf[5] = 16'hBEEF;

    //         iv a  b  d  dw w  wn wd        rdy ov opa       opb       od dw busy
    vt[0]  = '{1, 2, 5, 0, 0, 0, 0, 16'h0000, 1, 1, 16'h1234, 16'hBEEF, 0, 0, 8'h00};
    vt[1]  = '{1, 0, 1, 3, 1, 0, 0, 16'h0000, 1, 1, 16'h1000, 16'h1001, 3, 1, 8'h08};
    vt[2]  = '{1, 3, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h1000, 16'h1001, 3, 1, 8'h08};
    vt[3]  = '{1, 3, 0, 0, 0, 1, 3, 16'h00AA, 1, 1, 16'h00AA, 16'h1000, 0, 0, 8'h00};
    vt[4]  = '{1, 0, 0, 4, 1, 1, 4, 16'h4444, 1, 1, 16'h1000, 16'h1000, 4, 1, 8'h10};
    vt[5]  = '{1, 1, 2, 6, 1, 0, 0, 16'h0000, 1, 1, 16'h1001, 16'h1234, 6, 1, 8'h50};
    vt[6]  = '{1, 0, 1, 6, 1, 0, 0, 16'h0000, 0, 0, 16'h1001, 16'h1234, 6, 1, 8'h50};
    vt[7]  = '{1, 0, 1, 6, 1, 0, 0, 16'h0000, 0, 0, 16'h1001, 16'h1234, 6, 1, 8'h50};
    vt[8]  = '{1, 0, 1, 6, 1, 1, 6, 16'h6666, 1, 1, 16'h1000, 16'h1001, 6, 1, 8'h50};
    vt[9]  = '{0, 0, 0, 0, 0, 1, 4, 16'h0044, 1, 0, 16'h1000, 16'h1001, 6, 1, 8'h40};
    vt[10] = '{0, 0, 0, 0, 0, 1, 2, 16'h2222, 1, 0, 16'h1000, 16'h1001, 6, 1, 8'h40};
    vt[11] = '{1, 2, 2, 0, 0, 1, 2, 16'h2A2A, 1, 1, 16'h2A2A, 16'h2A2A, 0, 0, 8'h40};
    vt[12] = '{1, 5, 5, 5, 1, 0, 0, 16'h0000, 1, 1, 16'hBEEF, 16'hBEEF, 5, 1, 8'h60};

    do_reset();
    chk("rst_ov", ov1, 0);  chk("rst_opa", opa1, 0); chk("rst_opb", opb1, 0);
    chk("rst_od", od1, 0);  chk("rst_odw", odw1, 0); chk("rst_busy", busy1, 0);

    for (int i = 0; i < 13; i++) begin
      drive(vt[i].iv, vt[i].a, vt[i].b, vt[i].d, vt[i].dwen, vt[i].wen, vt[i].wn, vt[i].wd);
      #1;
      chk($sformatf("v%0d_rdy", i), rdy1, vt[i].rdy);
      tick();
      chk($sformatf("v%0d_ov", i), ov1, vt[i].ov);
      chk($sformatf("v%0d_opa", i), opa1, vt[i].opa);
      chk($sformatf("v%0d_opb", i), opb1, vt[i].opb);
      chk($sformatf("v%0d_od", i), od1, vt[i].od);
      chk($sformatf("v%0d_odw", i), odw1, vt[i].odw);
      chk($sformatf("v%0d_busy", i), busy1, vt[i].busy);
    end

    // Back-pressure: slot held for three cycles, then next instruction loads once.
    ordy = 1'b0;
    drive(1, 0, 1, 0, 0, 0, 0, 16'h0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_rdy", rdy1, 0);
      tick();
      chk("bp_ov", ov1, 1); chk("bp_opa", opa1, 16'hBEEF);
      chk("bp_opb", opb1, 16'hBEEF); chk("bp_od", od1, 5);
    end
    ordy = 1'b1;
    #1;
    chk("bp_rel_rdy", rdy1, 1);
    tick();
    chk("bp_rel_ov", ov1, 1); chk("bp_rel_opa", opa1, 16'h1000);
    chk("bp_rel_opb", opb1, 16'h1001); chk("bp_rel_od", od1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 16'h0);
    tick();
    chk("bp_drain_ov", ov1, 0);

    // Reset in the middle of a stall with pending writes.
    do_reset();
    drive(1, 0, 0, 3, 1, 0, 0, 16'h0); tick();
    drive(1, 0, 0, 6, 1, 0, 0, 16'h0); tick();
    ordy = 1'b0;
    drive(1, 3, 0, 0, 0, 0, 0, 16'h0);
    #1;
    chk("rs_pre_busy", busy1, 8'h48); chk("rs_pre_ov", ov1, 1); chk("rs_pre_rdy", rdy1, 0);
    rst_n = 1'b0;
    #1;
    chk("rs_low_rdy", rdy1, 0);
    tick();
    chk("rs_busy", busy1, 0); chk("rs_ov", ov1, 0); chk("rs_opa", opa1, 0);
    chk("rs_opb", opb1, 0);   chk("rs_od", od1, 0); chk("rs_odw", odw1, 0);
    ordy = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 0, 16'h0);
    #1;
    chk("rs_hold_rdy", rdy1, 0);
    tick();
    chk("rs_hold_ov", ov1, 0);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 16'h0);
    #1;
    chk("rs_rel_rdy", rdy1, 1);

    // Forwarding disabled: write-back to a source costs one extra cycle.
    do_reset();
    rf[3] = 16'h3333;
    drive(1, 0, 0, 3, 1, 0, 0, 16'h0); tick();
    chk("nb_busy", busy0, 8'h08);
    drive(1, 3, 0, 0, 0, 0, 0, 16'h0);
    #1;
    chk("nb_stall_rdy", rdy0, 0);
    tick();
    drive(1, 3, 0, 0, 0, 1, 3, 16'h00AA);
    #1;
    chk("nb_wb_rdy0", rdy0, 0);
    chk("nb_wb_rdy1", rdy1, 1);
    tick();
    chk("nb_byp_opa1", opa1, 16'h00AA);
    chk("nb_wb_ov0", ov0, 0);
    drive(1, 3, 0, 0, 0, 0, 0, 16'h0);
    #1;
    chk("nb_next_rdy0", rdy0, 1);
    tick();
    chk("nb_ov0", ov0, 1); chk("nb_opa0", opa0, 16'h00AA); chk("nb_busy0", busy0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reg_rd.md
Name: reg_rd

Overview:
- Operand-read stage of the cpu15 pipeline, between decode and execute.
- The read-side counterpart of the register write-back block. It selects two source operands from the REG_0..REG_7 outputs of write-back, bypasses a same-cycle write-back, and registers the result for execute.
- Holds an 8-bit pending-write scoreboard so that an instruction never reads a register whose write-back has not yet happened.

Parameters:
- DATA_W, 16, operand/register width; must match the write-back block.
- BYPASS_EN, 1: 1 forwards a same-cycle write-back to the operand. 0 stalls one cycle instead.

Ports:
- CLK_WB  in  1  clock; all state updates on the rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- REG_0..REG_7  in  DATA_W each  current register-file contents from write-back.
- IN_VALID  in  1  decode presents an instruction.
- IN_READY  out  1  stage accepts the instruction this cycle.
- N_REG_A  in  3  source A register index.
- N_REG_B  in  3  source B register index.
- N_REG_D  in  3  destination register index.
- D_WEN  in  1  instruction will write N_REG_D.
- WB_N_REG  in  3  write-back index; same net as the write-back block's N_REG.
- WB_REG_IN  in  DATA_W  write-back data.
- WB_REG_WEN  in  1  write-back enable.
- OUT_VALID  out  1  operand slot valid toward execute.
- OUT_READY  in  1  execute consumes the slot.
- OP_A  out  DATA_W  registered operand A.
- OP_B  out  DATA_W  registered operand B.
- OUT_N_REG_D  out  3  registered destination index.
- OUT_D_WEN  out  1  registered destination enable.
- BUSY  out  8  scoreboard; bit i set means a write to REG_i is pending.

Behaviour:
- Reset (RESET_N==0 at a rising edge):
  - OUT_VALID, OUT_D_WEN, OP_A, OP_B, OUT_N_REG_D and BUSY all go to 0.
  - IN_READY is forced to 0 while RESET_N is low.
  - Reset takes effect mid-stall as well: the held slot and all pending bits are discarded.
- wbhit(x) = WB_REG_WEN && WB_N_REG==x.
- hazA = BUSY[N_REG_A] && !(BYPASS_EN && wbhit(N_REG_A)); hazB is defined the same way for N_REG_B.
- hazD (WAW) = D_WEN && BUSY[N_REG_D] && !wbhit(N_REG_D).
- IN_READY = RESET_N && !hazA && !hazB && !hazD && (!OUT_VALID || OUT_READY). This is combinational.
- accept = IN_VALID && IN_READY.
- Operand select:
  - OP_A is loaded with WB_REG_IN if BYPASS_EN and wbhit(N_REG_A); otherwise with REG_[N_REG_A]. OP_B uses the same rule with N_REG_B.
  - Bypass also applies when the register is not busy, because REG_x updates on the same edge.
- With BYPASS_EN=0, wbhit on a source also counts as a hazard, giving a one-cycle stall.
- Latency: an operand accepted at edge n is visible on OP_A/OP_B after edge n, with OUT_VALID=1.
- Output slot:
  - On accept, load OP_A, OP_B, OUT_N_REG_D, OUT_D_WEN and set OUT_VALID=1.
  - Else if OUT_READY, set OUT_VALID=0.
  - Else hold all output fields stable.
- Scoreboard:
  - Set BUSY[N_REG_D] on accept when D_WEN=1.
  - Clear BUSY[WB_N_REG] when WB_REG_WEN=1.
  - Set and clear of the same bit in the same cycle: set wins.
  - Clearing a bit that is not set is a no-op.
- Sources A==B: legal, both operands get the same value.
- D equal to a source: legal; the source is read before D is marked busy.
- Throughput: one instruction per cycle when there is no hazard and OUT_READY stays high.

Decomposition:
- Package cpu15_pkg holds DATA_W=16, REG_ADDR_W=3 and NREG=8, shared with the write-back block.
- Sub-module reg_scoreboard holds the BUSY vector.
  - Inputs: set_en, set_idx, clr_en, clr_idx, plus clock and reset.
  - Outputs: busy[7:0].
- Operand mux, bypass, hazard logic and output slot stay in reg_rd.

Test Plan:
1. Reset, then REG_2=0x1234, REG_5=0xBEEF; issue A=2, B=5, D_WEN=0 → next cycle OP_A=0x1234, OP_B=0xBEEF, OUT_VALID=1, BUSY=0x00.
2. Issue D=3 with D_WEN=1, then next instruction with A=3 → BUSY=0x08 and IN_READY=0. Then WB_REG_WEN=1, N=3, data 0x00AA → accepted that cycle, OP_A=0x00AA, BUSY=0x00. Repeat with BYPASS_EN=0 → accepted one cycle later, OP_A=0x00AA.
3. Accept an instruction with D_WEN=1, D=4 in the same cycle WB writes reg 4 → BUSY[4]=1 afterwards (set wins).
4. OUT_READY=0 for 3 cycles with IN_VALID=1 → IN_READY=0, OP_A/OP_B/OUT_N_REG_D held. Then OUT_READY=1 → the next instruction loads one cycle later, with no loss or duplication.
5. BUSY[6]=1 and an instruction with D=6, D_WEN=1 → stalled (WAW) until WB writes 6, then accepted with BUSY[6]=1.
6. RESET_N=0 during a stall with BUSY=0x48, OUT_VALID=1 → after the edge, all outputs and BUSY are 0 and IN_READY=0 until RESET_N=1.
